// File: rtl/db_meter_multich.sv
// rtl/db_meter_multich.sv - multi-channel windowed |x| average to fixed-point dB meter (optional peak hold: DBCALC_PEAK_HOLD_EN)
module db_meter_multich #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int WIN_LOG2 = 10,
  parameter int FRAC_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [2:0]               in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [2:0]               out_ch,
  output logic [15:0]              out_db,
`ifdef DBCALC_PEAK_HOLD_EN
  output logic [15:0]              out_peak_db,
`endif
  output logic                     ch_err
);

  localparam int ACC_W = DATA_W + WIN_LOG2;
  // log2 value: 5-bit integer part (leading-one position) plus FRAC_W fraction bits
  localparam int LW    = 5 + FRAC_W;
  localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [WIN_LOG2-1:0] cnt [NUM_CH];

  logic [DATA_W-1:0]   mag;
  logic [ACC_W-1:0]    sel_acc;
  logic [WIN_LOG2-1:0] sel_cnt;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   avg;
  logic                ch_ok;
  logic                accept;
  logic                close;

  // S0 / S1 pipeline registers
  logic                v0, v1;
  logic [2:0]          ch0_r, ch1_r;
  logic [DATA_W-1:0]   avg0;
  logic [LW-1:0]       l1;
  logic                z1;

`ifdef DBCALC_PEAK_HOLD_EN
  logic [DATA_W-1:0]   pk [NUM_CH];
  logic [DATA_W-1:0]   sel_pk;
  logic [DATA_W-1:0]   pk_new;
  logic [DATA_W-1:0]   pk0;
  logic [LW-1:0]       pl1;
  logic                pz1;
`endif

  // Leading-one log2: {p, FRAC_W bits below the leading one}, zero-padded for small p
  function automatic logic [LW-1:0] log2_fx(input logic [DATA_W-1:0] v);
    logic [4:0]               p;
    logic [DATA_W+FRAC_W-1:0] ext;
    logic [FRAC_W-1:0]        f;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) p = i[4:0];
    end
    ext = {v, {FRAC_W{1'b0}}};
    f   = FRAC_W'(ext >> p);
    return {p, f};
  endfunction

  // dB scale: L * 1541 / 256 approximates L * 20*log10(2)
  function automatic logic [15:0] scale_db(input logic [LW-1:0] l);
    logic [31:0] prod;
    prod = 32'(l) * 32'd1541;
    return 16'(prod >> 8);
  endfunction

  // Magnitude, channel select and window-close decode for the incoming sample
  always_comb begin
    mag     = '0;
    sel_acc = '0;
    sel_cnt = '0;
    if (in_data[DATA_W-1]) begin
      if (in_data == {1'b1, {(DATA_W-1){1'b0}}})
        mag = {1'b0, {(DATA_W-1){1'b1}}};
      else
        mag = ~in_data + 1'b1;
    end else begin
      mag = in_data;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch == c[2:0]) begin
        sel_acc = acc[c];
        sel_cnt = cnt[c];
      end
    end
    ch_ok  = ({1'b0, in_ch} < NUM_CH_W);
    accept = in_valid && ch_ok && !clr;
    sum    = sel_acc + ACC_W'(mag);
    avg    = DATA_W'(sum >> WIN_LOG2);
    close  = accept && (sel_cnt == {WIN_LOG2{1'b1}});
  end

`ifdef DBCALC_PEAK_HOLD_EN
  // Peak of the current window including the incoming sample
  always_comb begin
    sel_pk = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch == c[2:0]) sel_pk = pk[c];
    end
    pk_new = (mag > sel_pk) ? mag : sel_pk;
  end
`endif

  // Per-channel accumulate / count, cleared on window close
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst || clr) begin
        acc[c] <= '0;
        cnt[c] <= '0;
`ifdef DBCALC_PEAK_HOLD_EN
        pk[c]  <= '0;
`endif
      end else if (accept && (in_ch == c[2:0])) begin
        if (close) begin
          acc[c] <= '0;
          cnt[c] <= '0;
`ifdef DBCALC_PEAK_HOLD_EN
          pk[c]  <= '0;
`endif
        end else begin
          acc[c] <= sum;
          cnt[c] <= cnt[c] + 1'b1;
`ifdef DBCALC_PEAK_HOLD_EN
          pk[c]  <= pk_new;
`endif
        end
      end
    end
  end

  // Sticky bad-channel flag, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst)
      ch_err <= 1'b0;
    else if (in_valid && !ch_ok && !clr)
      ch_err <= 1'b1;
  end

  // S0: capture window average on the close cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v0    <= 1'b0;
      ch0_r <= '0;
      avg0  <= '0;
`ifdef DBCALC_PEAK_HOLD_EN
      pk0   <= '0;
`endif
    end else begin
      v0 <= close;
      if (close) begin
        ch0_r <= in_ch;
        avg0  <= avg;
`ifdef DBCALC_PEAK_HOLD_EN
        pk0   <= pk_new;
`endif
      end
    end
  end

  // S1: log2 conversion with zero detect
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v1    <= 1'b0;
      ch1_r <= '0;
      l1    <= '0;
      z1    <= 1'b0;
`ifdef DBCALC_PEAK_HOLD_EN
      pl1   <= '0;
      pz1   <= 1'b0;
`endif
    end else begin
      v1 <= v0;
      if (v0) begin
        ch1_r <= ch0_r;
        l1    <= log2_fx(avg0);
        z1    <= (avg0 == '0);
`ifdef DBCALC_PEAK_HOLD_EN
        pl1   <= log2_fx(pk0);
        pz1   <= (pk0 == '0);
`endif
      end
    end
  end

  // S2: dB scaling; result outputs hold between pulses
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_db      <= '0;
`ifdef DBCALC_PEAK_HOLD_EN
      out_peak_db <= '0;
`endif
    end else begin
      out_valid <= v1;
      if (v1) begin
        out_ch      <= ch1_r;
        out_db      <= z1 ? 16'd0 : scale_db(l1);
`ifdef DBCALC_PEAK_HOLD_EN
        out_peak_db <= pz1 ? 16'd0 : scale_db(pl1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_db_meter_multich.sv
// tb/tb_db_meter_multich.sv - directed self-checking bench for db_meter_multich
module tb_db_meter_multich;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [2:0]  in_ch;
  logic signed [15:0] in_data;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic [15:0] out_db;
  logic        ch_err;
`ifdef DBCALC_PEAK_HOLD_EN
  logic [15:0] out_peak_db;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [2:0]  res_ch  [$];
  logic [15:0] res_db  [$];
  int          res_cyc [$];

  db_meter_multich dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_db     (out_db),
`ifdef DBCALC_PEAK_HOLD_EN
    .out_peak_db(out_peak_db),
`endif
    .ch_err     (ch_err)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Result logger, sampled away from the active edge
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      res_ch.push_back(out_ch);
      res_db.push_back(out_db);
      res_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] ch, input logic signed [15:0] d);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    res_ch.delete();
    res_db.delete();
    res_cyc.delete();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;

    // Reset values
    idle(2);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ch",    32'(out_ch),    0);
    check("rst_out_db",    32'(out_db),    0);
    check("rst_ch_err",    32'(ch_err),    0);
    rst = 1'b0;
    idle(5);
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_no_result", res_ch.size(), 0);

    // Constant level: 1024 x +256 on ch0, avg 256 -> L=128 -> 770
    for (int i = 0; i < 1023; i++) send(3'd0, 16'sd256);
    check("const_no_early", res_ch.size(), 0);
    send(3'd0, 16'sd256);
    check("const_lat_0", 32'(out_valid), 0);
    idle(1);
    check("const_lat_1", 32'(out_valid), 0);
    idle(1);
    check("const_valid", 32'(out_valid), 1);
    check("const_ch",    32'(out_ch),    0);
    check("const_db",    32'(out_db),    770);
    idle(1);
    check("const_pulse", 32'(out_valid), 0);
    check("const_count", res_ch.size(), 1);

    // Interleaved: ch0 +1 (db 0), ch1 -32768 saturating to 32767 (L=239 -> 1438)
    clear_log();
    for (int i = 0; i < 1024; i++) begin
      send(3'd0, 16'sd1);
      send(3'd1, -16'sd32768);
    end
    idle(4);
    check("ilv_count", res_ch.size(), 2);
    if (res_ch.size() == 2) begin
      check("ilv_r0_ch", 32'(res_ch[0]), 0);
      check("ilv_r0_db", 32'(res_db[0]), 0);
      check("ilv_r1_ch", 32'(res_ch[1]), 1);
      check("ilv_r1_db", 32'(res_db[1]), 1438);
      check("ilv_back_to_back", 32'(res_cyc[1] - res_cyc[0]), 1);
    end

    // Zero input on ch1
    clear_log();
    for (int i = 0; i < 1024; i++) send(3'd1, 16'sd0);
    idle(3);
    check("zero_count", res_ch.size(), 1);
    check("zero_ch",    32'(out_ch), 1);
    check("zero_db",    32'(out_db), 0);
    check("zero_noX",   32'($isunknown(out_db)), 0);

`ifdef DBCALC_PEAK_HOLD_EN
    // Peak hold: 1023 x 16 then 4096 -> avg 19 (403), peak 4096 (1155)
    clear_log();
    for (int i = 0; i < 1023; i++) send(3'd0, 16'sd16);
    send(3'd0, 16'sd4096);
    idle(2);
    check("peak_valid", 32'(out_valid), 1);
    check("peak_avg_db", 32'(out_db), 403);
    check("peak_db", 32'(out_peak_db), 1155);
`endif

    // Bad channel: flag set, no counter advances
    clear_log();
    send(3'd5, 16'sd1000);
    check("bad_ch_err", 32'(ch_err), 1);
    for (int i = 0; i < 1023; i++) send(3'd0, 16'sd4096);
    idle(4);
    check("bad_no_result", res_ch.size(), 0);

    // clr discards the partial window; post-clr 1024 x 64 -> L=96 -> 577
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    for (int i = 0; i < 1024; i++) send(3'd0, 16'sd64);
    idle(4);
    check("clr_count", res_ch.size(), 1);
    if (res_ch.size() == 1) begin
      check("clr_ch", 32'(res_ch[0]), 0);
      check("clr_db", 32'(res_db[0]), 577);
    end
    check("clr_keeps_ch_err", 32'(ch_err), 1);

    // rst clears the sticky flag
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_clears_ch_err", 32'(ch_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/db_meter_multich.md
Name: db_meter_multich

Overview:
- Parametrised multi-channel audio level meter. Successor to the single-channel threshold-table dB block.
- Accepts a channel-interleaved stream of signed PCM samples and averages |x| over a power-of-two window per channel.
- Converts each window average to a fixed-point dB value using a leading-one log2 approximation.
- Feeds the spectrum/level display path. One result per closed window per channel.

Parameters:
- DATA_W, 16: sample width, signed two's complement; 8..24.
- NUM_CH, 2: number of channels; 1..8.
- WIN_LOG2, 10: window length is 2^WIN_LOG2 samples per channel; 4..16.
- FRAC_W, 4: fractional bits of log2 and of the dB output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous soft clear of all accumulators, counters and pipeline.
- in_valid  in  1  sample strobe; one sample per cycle max; no backpressure.
- in_ch  in  3  channel index of the sample.
- in_data  in  DATA_W  signed sample.
- out_valid  out  1  one-cycle result pulse.
- out_ch  out  3  channel of the result.
- out_db  out  16  level in dB, unsigned, FRAC_W fractional bits (LSB = 1/16 dB at default).
- ch_err  out  1  sticky flag: a sample arrived with in_ch >= NUM_CH.

Behaviour:
- Reset (rst=1 at clk edge): all accumulators, counters and pipeline registers go to 0. out_valid=0, out_ch=0, out_db=0, ch_err=0.
- clr has the same effect as rst except ch_err is kept. clr is also applied when in_valid=1 in the same cycle, and that sample is dropped. clr kills any result still in the pipeline.
- Magnitude: abs(in_data). The most negative value saturates to 2^(DATA_W-1)-1.
- Per-channel state: acc[c], DATA_W+WIN_LOG2 bits; cnt[c], WIN_LOG2 bits.
- Accepted sample on channel c:
  - If cnt[c] < 2^WIN_LOG2-1: acc += mag and cnt++.
  - Otherwise the window closes. avg = (acc+mag) >> WIN_LOG2, so the closing sample is included. acc and cnt go to 0 in the same cycle.
- in_ch >= NUM_CH: the sample is ignored, no state changes, and ch_err is set until rst.
- Pipeline (fully pipelined; back-to-back closes on different channels are legal):
  - S0, the close cycle: avg and channel are registered.
  - S1, log2 stage:
    - p = bit position of the leading one of avg.
    - f = the FRAC_W bits immediately below the leading one, zero-padded if p < FRAC_W.
    - L = p*2^FRAC_W + f.
    - avg = 0 gives L = 0 and a zero flag.
  - S2, scale stage: out_db = (L * 1541) >> 8, truncated, where 1541/256 ≈ 20·log10(2). The zero flag forces out_db = 0.
- Latency: out_valid asserts exactly 2 cycles after the clk edge that accepts the window-closing sample. out_ch and out_db are valid only with out_valid and hold their value otherwise.
- Channels are independent: each one's window closes only on its own samples, with no cross-channel alignment.

Optional Feature:
- Macro: DBCALC_PEAK_HOLD_EN.
- Defined:
  - Adds output out_peak_db, 16 bits, and a per-channel register pk[c] holding the max magnitude seen in the current window (closing sample included).
  - pk[c] passes through the same log2/scale pipeline in parallel and is presented with out_valid.
  - pk[c] resets to 0 on window close, clr and rst.
- Not defined: no port, no peak registers; behaviour is otherwise identical.

Test Plan:
- Reset values: assert rst for 2 cycles -> all outputs 0. Then release rst, feed nothing -> out_valid stays 0.
- Constant level, default parameters: ch0 gets 1024 samples of +256 -> a single out_valid 2 cycles after the 1024th sample, with out_ch=0 and out_db=770 (48.125 dB).
- Full scale and saturation, interleaved: ch1 gets 1024 samples of -32768 while ch0 gets 1024 samples of +1, alternating ch0/ch1 every cycle.
  - Result 1: ch0, out_db=0.
  - Result 2 on the next cycle: ch1, avg=32767, L=239, out_db=1438.
- Zero input: 1024 samples of 0 on ch1 -> out_db=0, no X.
- Bad channel and clr: send in_ch=5 with NUM_CH=2 -> ch_err=1 and no counter change. Then feed 1000 samples on ch0, pulse clr, then feed 1024 more -> exactly one result, computed only from post-clr data. ch_err is still 1.
- Peak hold (macro defined): ch0 gets 1023 samples of +16 and one of +4096 -> out_peak_db = (192*1541)>>8 = 1155 (4096 gives L=12*16=192). out_db comes from avg=(1023*16+4096)>>10=19, i.e. L=4*16+3=67, out_db=(67*1541)>>8=403.
